// File: rtl/ram_bus_pkg.sv
// ram_bus_pkg: shared encodings for the RAM bus adapter
package ram_bus_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2, SZ_ILL = 2'd3} size_e;
  typedef enum logic [1:0] {IDLE = 2'd0, RDATA = 2'd1, RESP = 2'd2} state_e;
endpackage

// File: rtl/ram_bus_adapter_if.sv
// ram_bus_adapter_if: core-side request/response handshake bundle
interface ram_bus_adapter_if #(parameter int ADDR_WIDTH = 12);
  logic                           req_valid;
  logic                           req_ready;
  logic [ADDR_WIDTH+1:0]          req_addr;
  logic                           req_we;
  logic [1:0]                     req_size;
  logic                           req_unsigned;
  logic [ram_bus_pkg::DATA_W-1:0] req_wdata;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [ram_bus_pkg::DATA_W-1:0] rsp_rdata;
  logic                           rsp_err;
  modport master (
    output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ram_lane_fmt.sv
// ram_lane_fmt: byte-lane steering for stores and lane extraction/extension for loads
module ram_lane_fmt
  import ram_bus_pkg::*;
(
  input  logic [1:0]        st_size,
  input  logic [1:0]        st_off,
  input  logic [DATA_W-1:0] wdata,
  output logic [3:0]        we,
  output logic [DATA_W-1:0] din,
  output logic              misaligned,
  input  logic [1:0]        ld_size,
  input  logic [1:0]        ld_off,
  input  logic              ld_unsigned,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] rdata
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    we = st_size == SZ_BYTE ? 4'b0001 << st_off :
         st_size == SZ_HALF ? (st_off[1] ? 4'b1100 : 4'b0011) :
         st_size == SZ_WORD ? 4'b1111 : 4'b0000;
    din = st_size == SZ_BYTE ? {4{wdata[7:0]}} : st_size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    misaligned = (st_size == SZ_HALF && st_off[0]) || (st_size == SZ_WORD && st_off != 2'd0);
    b = dout[{ld_off, 3'b000} +: 8];
    h = ld_off[1] ? dout[31:16] : dout[15:0];
    rdata = ld_size == SZ_BYTE ? {{24{b[7] & ~ld_unsigned}}, b} :
            ld_size == SZ_HALF ? {{16{h[15] & ~ld_unsigned}}, h} : dout;
  end
endmodule

// File: rtl/ram_bus_adapter.sv
// ram_bus_adapter: single-outstanding load/store front-end for a byte-writable read-first RAM
module ram_bus_adapter
  import ram_bus_pkg::*;
#(
  parameter int SIZE       = 1024,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_bus_adapter_if.slave      bus,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_W-1:0]     ram_din,
  input  logic [DATA_W-1:0]     ram_dout
);
  localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH + 1)'(SIZE);
  state_e            state, nstate;
  logic              accept, err, mis;
  logic [1:0]        ld_size, ld_off;
  logic              ld_uns;
  logic [3:0]        fmt_we;
  logic [DATA_W-1:0] fmt_rdata;
  assign ram_addr = bus.req_addr[ADDR_WIDTH+1:2];
  assign accept   = bus.req_valid && state == IDLE && rst_n;
  assign err      = bus.req_size == SZ_ILL || mis || {1'b0, ram_addr} >= LIM;
  ram_lane_fmt u_fmt (
    .st_size(bus.req_size), .st_off(bus.req_addr[1:0]), .wdata(bus.req_wdata),
    .we(fmt_we), .din(ram_din), .misaligned(mis),
    .ld_size(ld_size), .ld_off(ld_off), .ld_unsigned(ld_uns), .dout(ram_dout), .rdata(fmt_rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nstate;
  always_comb begin
    nstate = state == IDLE  ? (accept ? (err || bus.req_we ? RESP : RDATA) : IDLE) :
             state == RDATA ? RESP :
             state == RESP && !bus.rsp_ready ? RESP : IDLE;
  end
  always_comb begin
    bus.req_ready = state == IDLE && rst_n;
    bus.rsp_valid = state == RESP;
    ram_we        = accept && bus.req_we && !err ? fmt_we : 4'b0000;
  end
  // Load data is captured at the end of RDATA so later RAM re-reads cannot disturb it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ld_size       <= SZ_BYTE;
      ld_off        <= 2'd0;
      ld_uns        <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else if (accept) begin
      ld_size       <= bus.req_size;
      ld_off        <= bus.req_addr[1:0];
      ld_uns        <= bus.req_unsigned;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= err;
    end else if (state == RDATA) begin
      bus.rsp_rdata <= fmt_rdata;
      bus.rsp_err   <= 1'b0;
    end
endmodule

// File: tb/tb_ram_bus_adapter.sv
// tb_ram_bus_adapter: randomized and directed checks of ram_bus_adapter against a word-array model
module tb_ram_bus_adapter;
  localparam int SIZE = 1024;
  localparam int AW   = 12;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout;
  logic [31:0]   mem [0:(1<<AW)-1];
  logic [31:0]   ref_mem [0:(1<<AW)-1];
  bit            loaded = 1'b0;
  int n_chk = 0, n_fail = 0;
  logic        o_rdy, o_er, o_st;
  logic [3:0]  o_we;
  logic [31:0] o_din, o_rd;
  logic [AW-1:0] o_addr;
  int          o_lat;
  time         o_tacc, o_ths;

  ram_bus_adapter_if #(.ADDR_WIDTH(AW)) bus();
  ram_bus_adapter #(.SIZE(SIZE), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(int i);
    return i * 32'h9E37_79B9 ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= pat(i);
      loaded <= 1'b1;
    end else begin
      for (int k = 0; k < 4; k++) if (ram_we[k]) mem[ram_addr][8*k +: 8] <= ram_din[8*k +: 8];
    end
    ram_dout <= mem[ram_addr];
  end

  function automatic logic m_err(logic [1:0] sz, logic [13:0] a);
    return sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || int'(a[13:2]) >= SIZE;
  endfunction
  function automatic logic [3:0] m_we(logic we, logic [1:0] sz, logic [13:0] a);
    if (!we || m_err(sz, a)) return 4'd0;
    return sz == 2'd0 ? 4'(1 << int'(a[1:0])) : sz == 2'd1 ? (a[1] ? 4'hC : 4'h3) : 4'hF;
  endfunction
  function automatic logic [31:0] m_din(logic [1:0] sz, logic [31:0] wd);
    return sz == 2'd0 ? wd[7:0] * 32'h0101_0101 : sz == 2'd1 ? wd[15:0] * 32'h0001_0001 : wd;
  endfunction
  function automatic logic [31:0] m_mask(logic [1:0] sz);
    return sz == 2'd0 ? 32'hFF : sz == 2'd1 ? 32'hFFFF : 32'hFFFF_FFFF;
  endfunction
  function automatic int m_shift(logic [1:0] sz, logic [13:0] a);
    return sz == 2'd0 ? 8 * int'(a[1:0]) : sz == 2'd1 ? 16 * int'(a[1]) : 0;
  endfunction
  function automatic logic [31:0] m_load(logic [1:0] sz, logic uns, logic [13:0] a);
    logic [31:0] mask, v;
    mask = m_mask(sz);
    v = (ref_mem[a[13:2]] >> m_shift(sz, a)) & mask;
    if (!uns && (v & (mask ^ (mask >> 1))) != 0) v = v | ~mask;
    return v;
  endfunction
  task automatic m_store(logic [1:0] sz, logic [13:0] a, logic [31:0] wd);
    int sh;
    logic [31:0] mask;
    sh = m_shift(sz, a);
    mask = m_mask(sz);
    ref_mem[a[13:2]] = (ref_mem[a[13:2]] & ~(mask << sh)) | ((wd & mask) << sh);
  endtask

  task automatic xact(input logic we, input logic [1:0] sz, input logic uns, input logic [13:0] a,
                      input logic [31:0] wd, input int hold);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz; bus.req_unsigned = uns;
    bus.req_addr = a; bus.req_wdata = wd; bus.rsp_ready = hold == 0;
    #1 o_rdy = bus.req_ready; o_we = ram_we; o_din = ram_din; o_addr = ram_addr;
    @(posedge clk); o_tacc = $time;
    #1 bus.req_valid = 1'b0;
    o_lat = 99; o_st = 1'b1; o_rd = 'x; o_er = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin o_lat = i; break; end
    end
    if (o_lat != 99) begin
      o_rd = bus.rsp_rdata; o_er = bus.rsp_err;
      for (int i = 0; i <= hold; i++) begin
        if (i > 0) @(negedge clk);
        if (!bus.rsp_valid || bus.rsp_rdata !== o_rd || bus.rsp_err !== o_er || bus.req_ready) o_st = 1'b0;
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); o_ths = $time;
      #1;
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
    bus.req_addr = 14'h010; bus.req_wdata = 32'h1234_5678; bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_chk++; if (bus.rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 0", bus.rsp_rdata); end
    n_chk++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
    n_chk++; if (ram_we !== 4'd0) begin n_fail++; $display("FAIL reset_ram_we: got %b want 0000", ram_we); end
    n_chk++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL release_req_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_word();
    xact(1'b1, 2'd2, 1'b0, 14'h010, 32'hDEAD_BEEF, 0);
    m_store(2'd2, 14'h010, 32'hDEAD_BEEF);
    n_chk++; if (o_rdy !== 1'b1) begin n_fail++; $display("FAIL word_st_ready: got %b want 1", o_rdy); end
    n_chk++; if (o_we !== 4'hF) begin n_fail++; $display("FAIL word_st_we: got %b want 1111", o_we); end
    n_chk++; if (o_din !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL word_st_din: got %h want deadbeef", o_din); end
    n_chk++; if (o_addr !== 12'd4) begin n_fail++; $display("FAIL word_st_addr: got %h want 004", o_addr); end
    n_chk++; if (o_lat !== 1) begin n_fail++; $display("FAIL word_st_lat: got %0d want 1", o_lat); end
    n_chk++; if (o_er !== 1'b0 || o_rd !== 32'd0) begin n_fail++; $display("FAIL word_st_rsp: got err=%b data=%h want err=0 data=0", o_er, o_rd); end
    xact(1'b0, 2'd2, 1'b0, 14'h010, 32'h0, 0);
    n_chk++; if (o_we !== 4'h0) begin n_fail++; $display("FAIL word_ld_we: got %b want 0000", o_we); end
    n_chk++; if (o_lat !== 2) begin n_fail++; $display("FAIL word_ld_lat: got %0d want 2", o_lat); end
    n_chk++; if (o_rd !== 32'hDEAD_BEEF || o_er !== 1'b0) begin n_fail++; $display("FAIL word_ld_data: got err=%b data=%h want err=0 data=deadbeef", o_er, o_rd); end
  endtask

  task automatic test_byte();
    logic [31:0] exp [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h8022_3344};
    xact(1'b1, 2'd2, 1'b0, 14'h010, 32'h1122_3344, 0);
    m_store(2'd2, 14'h010, 32'h1122_3344);
    xact(1'b1, 2'd0, 1'b0, 14'h013, 32'hABCD_EF80, 0);
    m_store(2'd0, 14'h013, 32'hABCD_EF80);
    n_chk++; if (o_we !== 4'b1000) begin n_fail++; $display("FAIL byte_st_we: got %b want 1000", o_we); end
    n_chk++; if (o_din !== 32'h8080_8080) begin n_fail++; $display("FAIL byte_st_din: got %h want 80808080", o_din); end
    for (int i = 0; i < 3; i++) begin
      xact(1'b0, i == 2 ? 2'd2 : 2'd0, i == 1, i == 2 ? 14'h010 : 14'h013, 32'h0, 0);
      n_chk++; if (o_rd !== exp[i] || o_rd !== m_load(i == 2 ? 2'd2 : 2'd0, i == 1, i == 2 ? 14'h010 : 14'h013))
        begin n_fail++; $display("FAIL byte_ld_%0d: got %h want %h", i, o_rd, exp[i]); end
    end
  endtask

  task automatic test_half();
    logic [13:0] ad [3]  = '{14'h012, 14'h012, 14'h010};
    logic        un [3]  = '{1'b0, 1'b1, 1'b0};
    logic [31:0] exp [3] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_7FFF};
    xact(1'b1, 2'd2, 1'b0, 14'h010, 32'h8001_7FFF, 0);
    m_store(2'd2, 14'h010, 32'h8001_7FFF);
    for (int i = 0; i < 3; i++) begin
      xact(1'b0, 2'd1, un[i], ad[i], 32'h0, 0);
      n_chk++; if (o_rd !== exp[i] || o_lat !== 2) begin n_fail++; $display("FAIL half_ld_%0d: got %h lat %0d want %h lat 2", i, o_rd, o_lat, exp[i]); end
    end
    xact(1'b1, 2'd1, 1'b0, 14'h022, 32'h1234_A5A5, 0);
    m_store(2'd1, 14'h022, 32'h1234_A5A5);
    n_chk++; if (o_we !== 4'b1100 || o_din !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL half_st: got we=%b din=%h want we=1100 din=a5a5a5a5", o_we, o_din); end
    xact(1'b0, 2'd2, 1'b0, 14'h020, 32'h0, 0);
    n_chk++; if (o_rd !== m_load(2'd2, 1'b0, 14'h020)) begin n_fail++; $display("FAIL half_st_readback: got %h want %h", o_rd, m_load(2'd2, 1'b0, 14'h020)); end
  endtask

  task automatic test_errors();
    logic        ew [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]  es [5] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0};
    logic [13:0] ea [5] = '{14'h011, 14'h002, 14'h020, 14'h1000, 14'h1003};
    for (int i = 0; i < 5; i++) begin
      xact(ew[i], es[i], 1'b0, ea[i], 32'hCAFE_F00D, 0);
      n_chk++; if (o_we !== 4'd0) begin n_fail++; $display("FAIL err_%0d_we: got %b want 0000", i, o_we); end
      n_chk++; if (o_er !== 1'b1 || o_rd !== 32'd0 || o_lat !== 1)
        begin n_fail++; $display("FAIL err_%0d_rsp: got err=%b data=%h lat=%0d want err=1 data=0 lat=1", i, o_er, o_rd, o_lat); end
    end
    xact(1'b0, 2'd2, 1'b0, 14'h010, 32'h0, 0);
    n_chk++; if (o_rd !== m_load(2'd2, 1'b0, 14'h010)) begin n_fail++; $display("FAIL err_no_write: got %h want %h", o_rd, m_load(2'd2, 1'b0, 14'h010)); end
  endtask

  task automatic test_backpressure();
    time t_hs;
    xact(1'b0, 2'd2, 1'b0, 14'h010, 32'h0, 5);
    t_hs = o_ths;
    n_chk++; if (o_st !== 1'b1) begin n_fail++; $display("FAIL bp_stable: got %b want 1", o_st); end
    n_chk++; if (o_rd !== m_load(2'd2, 1'b0, 14'h010) || o_lat !== 2) begin n_fail++; $display("FAIL bp_data: got %h lat %0d want %h lat 2", o_rd, o_lat, m_load(2'd2, 1'b0, 14'h010)); end
    xact(1'b1, 2'd0, 1'b0, 14'h030, 32'h0000_005C, 0);
    m_store(2'd0, 14'h030, 32'h0000_005C);
    n_chk++; if (o_rdy !== 1'b1 || o_tacc - t_hs != 10) begin n_fail++; $display("FAIL bp_next_accept: got ready=%b gap=%0t want ready=1 gap=10", o_rdy, o_tacc - t_hs); end
  endtask

  task automatic test_back_to_back();
    time t_prev;
    for (int i = 0; i < 8; i++) begin
      logic ld;
      ld = i >= 4;
      xact(!ld, 2'd2, 1'b0, 14'(14'h040 + 4 * (i % 4)), 32'h1111_0000 * i + 32'h77, 0);
      if (!ld) m_store(2'd2, 14'(14'h040 + 4 * (i % 4)), 32'h1111_0000 * i + 32'h77);
      if (ld) begin
        n_chk++; if (o_rd !== m_load(2'd2, 1'b0, 14'(14'h040 + 4 * (i % 4)))) begin n_fail++; $display("FAIL b2b_data_%0d: got %h want %h", i, o_rd, m_load(2'd2, 1'b0, 14'(14'h040 + 4 * (i % 4)))); end
      end
      if (i != 0 && i != 4) begin
        n_chk++; if (o_tacc - t_prev != (ld ? 30 : 20)) begin n_fail++; $display("FAIL b2b_gap_%0d: got %0t want %0d", i, o_tacc - t_prev, ld ? 30 : 20); end
      end
      t_prev = o_tacc;
    end
    xact(1'b0, 2'd3, 1'b0, 14'h000, 32'h0, 0);
    t_prev = o_tacc;
    xact(1'b1, 2'd1, 1'b0, 14'h001, 32'h0, 0);
    n_chk++; if (o_tacc - t_prev != 20 || o_er !== 1'b1) begin n_fail++; $display("FAIL b2b_err_gap: got %0t err %b want 20 err 1", o_tacc - t_prev, o_er); end
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 14'h010; bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0 || ram_we !== 4'd0)
      begin n_fail++; $display("FAIL midrst_outputs: got valid=%b ready=%b we=%b want 0 0 0000", bus.rsp_valid, bus.req_ready, ram_we); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_release: got ready=%b valid=%b want 1 0", bus.req_ready, bus.rsp_valid); end
    xact(1'b0, 2'd0, 1'b1, 14'h013, 32'h0, 0);
    n_chk++; if (o_rd !== m_load(2'd0, 1'b1, 14'h013) || o_lat !== 2) begin n_fail++; $display("FAIL midrst_fresh_load: got %h lat %0d want %h lat 2", o_rd, o_lat, m_load(2'd0, 1'b1, 14'h013)); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      logic we, uns, e;
      logic [1:0] sz;
      logic [13:0] a;
      logic [31:0] wd, er;
      int idx, hold;
      we = 1'($urandom % 2);
      uns = 1'($urandom % 2);
      sz = $urandom % 8 == 0 ? 2'd3 : 2'($urandom % 3);
      idx = $urandom % 16 == 0 ? SIZE + $urandom % 8 : $urandom % 16;
      a = {12'(idx), 2'($urandom % 4)};
      wd = $urandom;
      hold = $urandom % 3;
      e = m_err(sz, a);
      er = e || we ? 32'd0 : m_load(sz, uns, a);
      xact(we, sz, uns, a, wd, hold);
      n_chk++; if (o_rdy !== 1'b1 || o_addr !== a[13:2]) begin n_fail++; $display("FAIL rnd_%0d_accept: got ready=%b addr=%h want 1 %h", n, o_rdy, o_addr, a[13:2]); end
      n_chk++; if (o_we !== m_we(we, sz, a)) begin n_fail++; $display("FAIL rnd_%0d_we: got %b want %b", n, o_we, m_we(we, sz, a)); end
      if (m_we(we, sz, a) != 4'd0) begin
        n_chk++; if (o_din !== m_din(sz, wd)) begin n_fail++; $display("FAIL rnd_%0d_din: got %h want %h", n, o_din, m_din(sz, wd)); end
        m_store(sz, a, wd);
      end
      n_chk++; if (o_lat !== (e || we ? 1 : 2)) begin n_fail++; $display("FAIL rnd_%0d_lat: got %0d want %0d", n, o_lat, e || we ? 1 : 2); end
      n_chk++; if (o_er !== e || o_rd !== er) begin n_fail++; $display("FAIL rnd_%0d_rsp: got err=%b data=%h want err=%b data=%h", n, o_er, o_rd, e, er); end
      n_chk++; if (o_st !== 1'b1) begin n_fail++; $display("FAIL rnd_%0d_stable: got %b want 1", n, o_st); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = pat(i);
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_load();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_bus_adapter.md
# ram_bus_adapter

Request/response front-end for the single-port, byte-writable 32-bit code/data RAM (read-first, one-cycle registered read). It accepts one byte-addressed load/store at a time from the core's memory port. It generates per-lane write enables and lane-replicated write data, and issues the word address to the RAM. Load data is extracted from the registered RAM output, sign- or zero-extended, and returned with a valid/ready response handshake.

## Interface
- `SIZE`, 1024: RAM depth in 32-bit words.
- `ADDR_WIDTH`, 12: RAM word-address width; the byte address is `ADDR_WIDTH+2` bits.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  adapter can accept; `req_valid & req_ready` = accept.
- `req_addr`  in  ADDR_WIDTH+2  byte address.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_wdata`  in  32  store data, right-justified.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  misaligned, illegal size, or out-of-range.
- `ram_we`  out  4  per-byte write enable to the RAM.
- `ram_addr`  out  ADDR_WIDTH  RAM word address.
- `ram_din`  out  32  RAM write data.
- `ram_dout`  in  32  RAM registered read data, valid the cycle after the address edge.

## Operation
- FSM states: IDLE, RDATA, RESP. Reset → IDLE.
- `req_ready` = (state == IDLE) & `rst_n`. Only one request is outstanding at a time.
- `ram_addr` = `req_addr[ADDR_WIDTH+1:2]` at all times (combinational).
- Error conditions on accept, any of:
  - `req_size` == 3.
  - Half access with `addr[0]` = 1.
  - Word access with `addr[1:0]` != 0.
  - Word index ≥ `SIZE`.
- Errored request: no RAM write. IDLE → RESP with `rsp_err` = 1 and `rsp_rdata` = 0.
- Accepted good store:
  - `ram_we` is asserted combinationally in the accept cycle.
  - Byte: `ram_we` = 1 << `addr[1:0]`; `ram_din` = `wdata[7:0]` replicated ×4.
  - Half: `ram_we` = 0011 or 1100 (per `addr[1]`); `ram_din` = `wdata[15:0]` replicated ×2.
  - Word: `ram_we` = 1111; `ram_din` = `wdata`.
  - IDLE → RESP; `rsp_err` = 0; `rsp_rdata` = 0.
- Accepted good load:
  - `ram_we` = 0. Latch `addr[1:0]`, size, and unsigned flag. IDLE → RDATA.
  - In RDATA: select the lane from `ram_dout` (byte lane `addr[1:0]`, half lane `addr[1]`).
  - Extend per the unsigned flag and register into `rsp_rdata`. RDATA → RESP.
- RESP: hold `rsp_valid` = 1 and the data stable until `rsp_ready`; then → IDLE.
- `ram_we` = 0 whenever not (IDLE & `req_valid` & good store), and whenever `rst_n` = 0.

## Timing
- Reset values:
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, `ram_we` = 0.
  - `req_ready` = 0 while in reset, 1 from the first cycle after release.
- Store/error accepted at edge E: `rsp_valid` = 1 in the cycle after E. The store's RAM write also lands at E.
- Load accepted at edge E:
  - RAM samples the address at E; `ram_dout` is valid in cycle E+1.
  - `rsp_valid` = 1 in cycle E+2 (load latency 2).
- Back-to-back, with `rsp_ready` tied high:
  - Store or error: one request every 2 cycles.
  - Load: one request every 3 cycles.
- `ram_addr` changes during RDATA/RESP only cause harmless RAM re-reads. The response is captured from `ram_dout` at the end of RDATA, before any later read can alter it.
- Reset asserted mid-operation: immediate return to IDLE; any pending response is dropped. A store whose write edge has already occurred stays in RAM.
- `rsp_ready` high in the same cycle `rsp_valid` rises: completes in that cycle.

## Structure
- Package `ram_bus_pkg` holds:
  - Size encodings: `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - FSM state encoding.
  - Width constant for data (32).
- Sub-module `ram_lane_fmt` (purely combinational) performs:
  - Store direction: size + `addr[1:0]` + wdata → `we[3:0]`, `din`, `misaligned`.
  - Load direction: `dout` + latched size/offset/unsigned → extended data.

## Test plan
- Word store, then word load, at byte address 0x010 with `wdata` 0xDEADBEEF:
  - Store: `ram_we` = 1111 during the accept cycle.
  - Load: `rsp_rdata` = 0xDEADBEEF, `rsp_valid` 2 cycles after accept.
- Byte store 0x80 at 0x013 over word 0x11223344:
  - Store: `ram_we` = 1000, `ram_din` = 0x80808080.
  - Signed byte load at 0x013 → 0xFFFFFF80.
  - Unsigned byte load at 0x013 → 0x00000080.
- Half load at 0x012 from word 0x8001_7FFF:
  - Signed → 0xFFFF8001.
  - Unsigned → 0x00008001.
  - Half at 0x010, signed → 0x00007FFF.
- Errors:
  - Half store at 0x011 → no `ram_we`; `rsp_err` = 1, `rsp_rdata` = 0 one cycle later.
  - Word load at 0x002 → `rsp_err` = 1.
  - `req_size` = 3 → `rsp_err` = 1.
  - Word index = `SIZE` → `rsp_err` = 1.
- Backpressure:
  - Hold `rsp_ready` = 0 for 5 cycles after a load completes → `rsp_valid`/`rsp_rdata` stable and `req_ready` = 0 throughout.
  - Release → next request accepted the cycle after the handshake.
- Reset mid-load: drop `rst_n` during RDATA → `rsp_valid` = 0 immediately; after release, `req_ready` = 1 and a fresh load returns correct data.
